// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one unsigned 8x8 Wallace-tree multiplier among
// NREQ requesters. Operands are registered in front of the multiplier and the
// product is registered on the response side, so the multiplier sits alone
// between two register stages.

// Unsigned 8x8 multiplier: AND-array partial products, a carry-save (3:2)
// reduction tree down to two rows, then a 16-bit carry-select final adder.
module wallace_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // Sum bit of a 3:2 compressor row.
  function automatic logic [15:0] csa_s(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  // Carry row of a 3:2 compressor; the bit shifted out of bit 15 is dropped
  // because the true product always fits in 16 bits.
  function automatic logic [15:0] csa_c(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1;
  logic [15:0] s2, c2, s3, c3;
  logic [15:0] s4, c4;
  logic [15:0] s5, c5;

  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = {8'h00, a & {8{b[i]}}} << i;
  end

  // Level 1: 8 rows -> 6 rows
  assign s0 = csa_s(pp[0], pp[1], pp[2]);
  assign c0 = csa_c(pp[0], pp[1], pp[2]);
  assign s1 = csa_s(pp[3], pp[4], pp[5]);
  assign c1 = csa_c(pp[3], pp[4], pp[5]);

  // Level 2: 6 rows -> 4 rows
  assign s2 = csa_s(s0, c0, s1);
  assign c2 = csa_c(s0, c0, s1);
  assign s3 = csa_s(c1, pp[6], pp[7]);
  assign c3 = csa_c(c1, pp[6], pp[7]);

  // Level 3: 4 rows -> 3 rows
  assign s4 = csa_s(s2, c2, s3);
  assign c4 = csa_c(s2, c2, s3);

  // Level 4: 3 rows -> 2 rows
  assign s5 = csa_s(s4, c4, c3);
  assign c5 = csa_c(s4, c4, c3);

  // Carry-select final adder in 4-bit blocks. Each upper block precomputes
  // its sum for carry-in 0 and 1 and the incoming carry only picks one.
  logic       cb0, cb1, cb2;
  logic [4:0] r1_0, r1_1, r2_0, r2_1;
  logic [3:0] r3_0, r3_1;

  assign {cb0, p[3:0]} = {1'b0, s5[3:0]} + {1'b0, c5[3:0]};

  assign r1_0    = {1'b0, s5[7:4]} + {1'b0, c5[7:4]};
  assign r1_1    = {1'b0, s5[7:4]} + {1'b0, c5[7:4]} + 5'd1;
  assign p[7:4]  = cb0 ? r1_1[3:0] : r1_0[3:0];
  assign cb1     = cb0 ? r1_1[4] : r1_0[4];

  assign r2_0    = {1'b0, s5[11:8]} + {1'b0, c5[11:8]};
  assign r2_1    = {1'b0, s5[11:8]} + {1'b0, c5[11:8]} + 5'd1;
  assign p[11:8] = cb1 ? r2_1[3:0] : r2_0[3:0];
  assign cb2     = cb1 ? r2_1[4] : r2_0[4];

  assign r3_0     = s5[15:12] + c5[15:12];
  assign r3_1     = s5[15:12] + c5[15:12] + 4'd1;
  assign p[15:12] = cb2 ? r3_1 : r3_0;

endmodule

// state   | meaning
// IDLE    | waiting for any req_valid; grants one requester combinationally
// CALC    | operands registered, multiplier settling; product captured at edge
// RESP    | response held on rsp_* until rsp_ready handshake
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [8*NREQ-1:0]  req_a,
  input  logic [8*NREQ-1:0]  req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_product,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // NREQ in the one-bit-wider index domain used for the modulo wrap.
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt, grant_idx, id;
  logic [IDW:0]   scan_idx, ptr_inc;
  logic           any_valid, accept;
  logic [7:0]     op_a, op_b, sel_a, sel_b;
  logic [15:0]    mult_p;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
      if (!any_valid && req_valid[scan_idx[IDW-1:0]]) begin
        any_valid = 1'b1;
        grant_idx = scan_idx[IDW-1:0];
      end
    end
  end

  // Operand mux for the granted requester; only loaded into op_a/op_b.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[8*i +: 8];
        sel_b = req_b[8*i +: 8];
      end
    end
  end

  assign ptr_inc    = {1'b0, grant_idx} + (IDW+1)'(1);
  assign rr_ptr_nxt = (ptr_inc == NREQ_W) ? '0 : ptr_inc[IDW-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_valid) state_nxt = ST_CALC;
      ST_CALC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; grants are suppressed while reset is held.
  always_comb begin
    accept    = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    req_ready = '0;
    case (state)
      ST_IDLE: accept = rst_n & any_valid;
      ST_CALC: busy = 1'b1;
      ST_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (grant_idx == IDW'(i));
    end
  end

  // Operand capture on grant, product capture leaving CALC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      id          <= '0;
      rsp_product <= '0;
      rsp_id      <= '0;
    end else begin
      if (accept) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        id     <= grant_idx;
        rr_ptr <= rr_ptr_nxt;
      end
      if (state == ST_CALC) begin
        rsp_product <= mult_p;
        rsp_id      <= id;
      end
    end
  end

  wallace_multiplier u_mult (
    .a (op_a),
    .b (op_b),
    .p (mult_p)
  );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter (NREQ=4): directed scenarios plus randomized
// traffic, checked against a round-robin/arithmetic reference model.
module tb_mult_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_product;
  logic [1:0]  rsp_id;
  logic        busy;

  int total = 0;
  int bad = 0;
  int exp_ptr = 0;
  int cyc = 0;
  int last_grant = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: first valid index at or after exp_ptr, modulo NREQ.
  function automatic int model_grant(input logic [3:0] v);
    for (int off = 0; off < NREQ; off++) begin
      int idx = (exp_ptr + off) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  // One full transaction starting in IDLE. vmask must be nonzero.
  // after_mask: req_valid presented once the grant is taken.
  // hold: cycles rsp_ready stays low after rsp_valid rises.
  // exp_period: required cycles since previous grant (0 = don't check).
  task automatic txn(input logic [3:0] vmask, input logic [3:0] after_mask,
                     input int hold, input int exp_period, output int g);
    logic [15:0] ep;
    req_valid = vmask;
    rsp_ready = (hold == 0);
    #1;
    g = model_grant(vmask);
    check("grant", 32'(req_ready), 32'(1) << g);
    check("idle_busy", 32'(busy), 32'(0));
    if (exp_period > 0) check("grant_period", 32'(cyc - last_grant), 32'(exp_period));
    last_grant = cyc;
    ep = 16'(req_a[8*g +: 8]) * 16'(req_b[8*g +: 8]);
    exp_ptr = (g + 1) % NREQ;
    tick();
    req_valid = after_mask;
    if (!after_mask[g]) set_req(g, 8'($urandom), 8'($urandom));
    #1;
    check("calc_ready", 32'(req_ready), 32'(0));
    check("calc_busy", 32'(busy), 32'(1));
    check("calc_rsp_valid", 32'(rsp_valid), 32'(0));
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'(1));
    check("rsp_product", 32'(rsp_product), 32'(ep));
    check("rsp_id", 32'(rsp_id), 32'(g));
    check("rsp_ready_low", 32'(req_ready), 32'(0));
    check("rsp_busy", 32'(busy), 32'(1));
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 32'(1));
      check("hold_product", 32'(rsp_product), 32'(ep));
      check("hold_id", 32'(rsp_id), 32'(g));
      check("hold_ready", 32'(req_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    tick();
    check("post_rsp_valid", 32'(rsp_valid), 32'(0));
    check("post_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    int g;
    int prev_hold;
    logic [7:0] corner [7];
    logic [3:0] vm, am;

    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h02; corner[3] = 8'h7F;
    corner[4] = 8'h80; corner[5] = 8'hFE; corner[6] = 8'hFF;

    // Reset with every requester valid: nothing may be granted.
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = $urandom;
    req_b     = $urandom;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_product", 32'(rsp_product), 32'(0));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst_n     = 1'b1;
    req_valid = 4'h0;
    #1;
    check("idle_no_req", 32'(req_ready), 32'(0));
    tick();
    check("idle_stay", 32'(busy), 32'(0));

    // Single request, full-scale operands.
    set_req(2, 8'hFF, 8'hFF);
    txn(4'b0100, 4'b0000, 0, 0, g);
    check("ff_ff_product", 32'(rsp_product), 32'h0000FE01);

    // Re-reset so the pointer restarts at 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_ptr = 0;

    // All requesters continuously valid: strict rotation, 3 cycles apart.
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'h10);
    for (int k = 0; k < 5; k++) begin
      txn(4'hF, 4'hF, 0, (k > 0) ? 3 : 0, g);
      check("rot_product", 32'(rsp_product), 32'(((k % NREQ) + 1) * 16));
    end
    req_valid = 4'h0;
    tick();

    // Backpressure while requester 0 waits; it is granted right afterwards.
    set_req(1, 8'h0C, 8'h0D);
    set_req(0, 8'h21, 8'h03);
    txn(4'b0010, 4'b0001, 5, 0, g);
    check("bp_product", 32'(rsp_product), 32'h0000009C);
    txn(4'b0001, 4'b0000, 0, 0, g);

    // Wrap and skip: grant 3, then only 1 and 2 valid.
    set_req(3, 8'h05, 8'h07);
    txn(4'b1000, 4'b0000, 0, 0, g);
    set_req(1, 8'h11, 8'h22);
    set_req(2, 8'h33, 8'h44);
    txn(4'b0110, 4'b0100, 0, 0, g);
    txn(4'b0100, 4'b0000, 0, 3, g);

    // Reset while in CALC discards the pending response and the pointer.
    set_req(3, 8'h99, 8'h77);
    req_valid = 4'b1000;
    tick();
    rst_n     = 1'b0;
    req_valid = 4'b1001;
    tick();
    check("midrst_ready", 32'(req_ready), 32'(0));
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_product", 32'(rsp_product), 32'(0));
    check("midrst_id", 32'(rsp_id), 32'(0));
    rst_n   = 1'b1;
    exp_ptr = 0;
    set_req(0, 8'h12, 8'h34);
    txn(4'b1001, 4'b0000, 0, 0, g);

    // Corner operand sweep through requester 1.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        set_req(1, corner[i], corner[j]);
        txn(4'b0010, 4'b0000, 0, 0, g);
      end
    end

    // Random operands through one random requester at a time.
    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, NREQ - 1);
      set_req(r, 8'($urandom), 8'($urandom));
      txn(4'(1 << r), 4'b0000, 0, 0, g);
    end

    // Random mixed traffic: masks, drops, backpressure and idle gaps.
    prev_hold = -1;
    for (int n = 0; n < 300; n++) begin
      int hold;
      if ($urandom_range(0, 7) == 0) begin
        req_valid = 4'h0;
        rsp_ready = 1'($urandom);
        #1;
        check("gap_ready", 32'(req_ready), 32'(0));
        tick();
        check("gap_busy", 32'(busy), 32'(0));
        prev_hold = -1;
      end
      vm   = 4'($urandom_range(1, 15));
      am   = 4'($urandom);
      hold = $urandom_range(0, 2);
      for (int i = 0; i < NREQ; i++) set_req(i, 8'($urandom), 8'($urandom));
      txn(vm, am, hold, (prev_hold >= 0) ? (3 + prev_hold) : 0, g);
      prev_hold = hold;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
